// File: rtl/led_pkg.sv
// Shared definitions for the LED blink-code transmitter: state encoding,
// the default code width and a compile-time helper for sizing the tick counter.
package led_pkg;

   localparam int CODE_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2,
      GAP  = 2'd3
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter: load_val is taken on a load cycle, then the count
// decrements to zero and holds there; done is high while the count is zero.
module tick_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the processes are evaluated in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/led_blink_tx.sv
// Blinks an active-low LED N times for an accepted code N, followed by a long
// dark gap. Define LED_BLINK_REPEAT_EN to replay the stored code endlessly.
module led_blink_tx
   import led_pkg::*;
#(
   parameter int ON_TICKS  = 25_000_000,
   parameter int OFF_TICKS = 25_000_000,
   parameter int GAP_TICKS = 100_000_000,
   parameter int CODE_W    = CODE_W_DEF
) (
   input  logic              FPGA_CLK,
   input  logic              RST_N,
   input  logic [CODE_W-1:0] code,
   input  logic              code_valid,
   output logic              code_ready,
   output logic              busy,
   output logic              LED1
);

   localparam int MAX_T = max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
   localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   // The timer is loaded with ticks-1 so that the zero count is the last cycle.
   localparam logic [TW-1:0] ON_LD  = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0] OFF_LD = TW'(OFF_TICKS - 1);
   localparam logic [TW-1:0] GAP_LD = TW'(GAP_TICKS - 1);

   state_e            state_q, state_d;
   logic [CODE_W-1:0] blink_q, blink_d;
   logic              led_q, busy_q, ready_q;
   logic              hs, start, timer_load, timer_done;
   logic [CODE_W-1:0] start_code;
   logic [TW-1:0]     timer_val;

`ifdef LED_BLINK_REPEAT_EN
   logic [CODE_W-1:0] code_q, code_d;
`endif

   assign hs = code_valid & ready_q;

   tick_timer #(.W(TW)) u_timer (
      .clk      (FPGA_CLK),
      .rst_n    (RST_N),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   // NOTE: every signal written below gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      blink_d    = blink_q;
      timer_load = 1'b0;
      timer_val  = ON_LD;
      start      = 1'b0;
      start_code = code;
`ifdef LED_BLINK_REPEAT_EN
      code_d     = hs ? code : code_q;
`endif
      case (state_q)
         IDLE: start = hs;
         ON: if (timer_done) begin
            blink_d    = blink_q - 1'b1;
            timer_load = 1'b1;
            if (blink_q != CODE_W'(1)) begin
               state_d   = OFF;
               timer_val = OFF_LD;
            end else begin
               state_d   = GAP;
               timer_val = GAP_LD;
            end
         end
         OFF: if (timer_done) begin
            state_d    = ON;
            timer_load = 1'b1;
            timer_val  = ON_LD;
         end
         GAP: if (timer_done) begin
`ifdef LED_BLINK_REPEAT_EN
            // A code accepted on the final gap cycle takes effect immediately.
            start      = 1'b1;
            start_code = hs ? code : code_q;
`else
            state_d    = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         blink_d    = start_code;
         timer_load = 1'b1;
         if (start_code != '0) begin
            state_d   = ON;
            timer_val = ON_LD;
         end else begin
            state_d   = GAP;
            timer_val = GAP_LD;
         end
      end
   end

   always_ff @(posedge FPGA_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         blink_q <= '0;
         led_q   <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         blink_q <= blink_d;
         led_q   <= (state_d != ON);
         busy_q  <= (state_d != IDLE);
`ifdef LED_BLINK_REPEAT_EN
         ready_q <= (state_d == IDLE) || (state_d == GAP);
`else
         ready_q <= (state_d == IDLE);
`endif
      end
   end

`ifdef LED_BLINK_REPEAT_EN
   always_ff @(posedge FPGA_CLK or negedge RST_N) begin
      if (!RST_N) code_q <= '0;
      else        code_q <= code_d;
   end
`endif

   assign LED1       = led_q;
   assign busy       = busy_q;
   assign code_ready = ready_q;

endmodule

// File: tb/tb_led_blink_tx.sv
// Self-checking bench for led_blink_tx: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the expected LED pattern.
module tb_led_blink_tx;

   localparam int ON  = 3;
   localparam int OFF = 2;
   localparam int GAP = 5;
   localparam int W   = 4;

   logic         FPGA_CLK = 1'b0;
   logic         RST_N    = 1'b0;
   logic [W-1:0] code     = '0;
   logic         code_valid = 1'b0;
   logic         code_ready, busy, LED1;

   always #10 FPGA_CLK = ~FPGA_CLK;

   led_blink_tx #(
      .ON_TICKS  (ON),
      .OFF_TICKS (OFF),
      .GAP_TICKS (GAP),
      .CODE_W    (W)
   ) dut (
      .FPGA_CLK   (FPGA_CLK),
      .RST_N      (RST_N),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .busy       (busy),
      .LED1       (LED1)
   );

   typedef struct packed {
      logic led;
      logic busy;
      logic gap;
   } slot_t;

   slot_t        q[$];
   logic         e_led = 1'b1, e_busy = 1'b0, e_ready = 1'b0, e_gap = 1'b0;
   logic         started = 1'b0;
   logic [W-1:0] m_code = '0;
   int           last_code = 0;
   int           busy_run = 0;
   int           checks = 0;
   int           errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // Expected cycle-by-cycle pattern for one transmission of code n.
   task automatic push_seq(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (ON) q.push_back('{led: 1'b0, busy: 1'b1, gap: 1'b0});
         if (i < n - 1) repeat (OFF) q.push_back('{led: 1'b1, busy: 1'b1, gap: 1'b0});
      end
      repeat (GAP) q.push_back('{led: 1'b1, busy: 1'b1, gap: 1'b1});
   endtask

   function automatic int busy_len(input int n);
      return (n == 0) ? GAP : n * ON + (n - 1) * OFF + GAP;
   endfunction

   task automatic model_edge();
      slot_t s;
      logic  hs;
      hs = code_valid && e_ready;
      if (hs) begin
         m_code    = code;
         last_code = int'(code);
         started   = 1'b1;
      end
`ifdef LED_BLINK_REPEAT_EN
      if (q.size() == 0 && started) push_seq(int'(m_code));
`else
      if (q.size() == 0 && hs) push_seq(int'(code));
`endif
      if (q.size() > 0) begin
         s      = q.pop_front();
         e_led  = s.led;
         e_busy = s.busy;
         e_gap  = s.gap;
      end else begin
         e_led  = 1'b1;
         e_busy = 1'b0;
         e_gap  = 1'b0;
      end
`ifdef LED_BLINK_REPEAT_EN
      e_ready = !e_busy || e_gap;
`else
      e_ready = !e_busy;
`endif
   endtask

   task automatic compare();
      check("led1", 32'(LED1), 32'(e_led));
      check("busy", 32'(busy), 32'(e_busy));
      check("code_ready", 32'(code_ready), 32'(e_ready));
`ifndef LED_BLINK_REPEAT_EN
      if (busy) begin
         busy_run++;
      end else if (busy_run > 0) begin
         check("busy_len", 32'(busy_run), 32'(busy_len(last_code)));
         busy_run = 0;
      end
`endif
   endtask

   // Drive inputs for the coming edge, advance the model on it, check after.
   task automatic step(input logic v, input logic [W-1:0] c);
      code_valid = v;
      code       = c;
      @(posedge FPGA_CLK);
      if (RST_N) model_edge();
      @(negedge FPGA_CLK);
      compare();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0);
   endtask

   task automatic model_reset();
      q.delete();
      e_led    = 1'b1;
      e_busy   = 1'b0;
      e_ready  = 1'b0;
      e_gap    = 1'b0;
      started  = 1'b0;
      busy_run = 0;
   endtask

   initial begin
      // Power-on reset.
      model_reset();
      repeat (2) @(negedge FPGA_CLK);
      compare();
      RST_N = 1'b1;
      step(1'b0, '0);

      // code=3: three pulses then the gap.
      step(1'b1, 4'd3);
      idle(20);

      // code=0: gap only.
      step(1'b1, 4'd0);
      idle(8);

      // Maximum code: 15 pulses.
      step(1'b1, 4'd15);
      idle(80);

      // code=2 with a new code offered while busy; it must be ignored.
      step(1'b1, 4'd2);
      idle(3);
      step(1'b1, 4'd5);
      idle(14);

      // Asynchronous reset in cycle 7 of a code=3 sequence.
      step(1'b1, 4'd3);
      idle(6);
      RST_N = 1'b0;
      #1;
      check("rst_led1", 32'(LED1), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(code_ready), 32'd0);
      model_reset();
      @(negedge FPGA_CLK);
      compare();
      RST_N = 1'b1;
      step(1'b0, '0);
      idle(3);

`ifdef LED_BLINK_REPEAT_EN
      // code=1, then code=2 offered during the gap; the 2-pulse pattern repeats.
      step(1'b1, 4'd1);
      idle(4);
      step(1'b1, 4'd2);
      idle(40);
`endif

      // Random traffic, including offers while busy.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 3) == 0), W'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
